// File: rtl/corelet_seq.sv
// corelet_seq: run sequencer for a systolic corelet.
//
// One run walks len_kij kernel positions. Each position does the same steps:
//   WFILL  - copy row weight vectors from SRAM into L0
//   WLOAD  - read them out of L0 into the PE array
//   WFLUSH - let the weights propagate for col cycles
//   XFILL  - copy len_nij activation vectors from SRAM into L0
//   XEXEC  - stream them through the array
//   DRAIN  - pop len_onij rows from the OFIFO and accumulate them
// After the last kernel position the sequencer pulses done and returns to IDLE.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        one-cycle run request, only honoured in IDLE
//   l0_full      L0 cannot take a write this cycle (fill steps stall)
//   ofifo_valid  OFIFO holds at least one complete row
//   inst[34:0]   instruction word: [0] load, [1] execute, [2] l0_wr,
//                [3] l0_rd, [6] ofifo_rd, [33] acc, other bits always 0
//   xmem_cen     active-low SRAM enable
//   xmem_addr    SRAM read address
//   busy         high whenever the sequencer is not in IDLE
//   done         one-cycle pulse at run completion
//
// inst, xmem_cen and xmem_addr are registered: they show what the sequencer
// decided in the previous cycle.
module corelet_seq #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_nij  = 36,
    parameter int len_onij = 16,
    parameter int len_kij  = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        l0_full,
    input  logic        ofifo_valid,
    output logic [34:0] inst,
    output logic        xmem_cen,
    output logic [10:0] xmem_addr,
    output logic        busy,
    output logic        done
);

    // One phase counter serves every step, so it is sized for the largest step.
    localparam int MAX_A     = (row > col) ? row : col;
    localparam int MAX_B     = (len_nij > len_onij) ? len_nij : len_onij;
    localparam int PHASE_LIM = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int PW        = $clog2(PHASE_LIM) + 1;
    localparam int KW        = $clog2(len_kij) + 1;

    localparam logic [PW-1:0] ROW_LAST  = PW'(row - 1);
    localparam logic [PW-1:0] COL_LAST  = PW'(col - 1);
    localparam logic [PW-1:0] NIJ_LAST  = PW'(len_nij - 1);
    localparam logic [PW-1:0] ONIJ_LAST = PW'(len_onij - 1);
    localparam logic [KW-1:0] KIJ_LAST  = KW'(len_kij - 1);

    typedef enum logic [2:0] {
        IDLE,
        WFILL,
        WLOAD,
        WFLUSH,
        XFILL,
        XEXEC,
        DRAIN,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]  kij_q, kij_d;
    logic [10:0]    addr_q, addr_d;
    logic [34:0]    inst_q, inst_d;
    logic           cen_q, cen_d;
    logic [10:0]    xaddr_q, xaddr_d;

    // Next-state and next-output logic. The SRAM address counter runs on
    // across kernel positions and only restarts when a new run begins; it
    // wraps naturally at 11 bits. A stalled fill cycle changes nothing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kij_d   = kij_q;
        addr_d  = addr_q;
        inst_d  = '0;
        cen_d   = 1'b1;
        xaddr_d = addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WFILL;
                    cnt_d   = '0;
                    kij_d   = '0;
                    addr_d  = '0;
                end
            end

            WFILL: begin
                if (!l0_full) begin
                    inst_d[2] = 1'b1;
                    cen_d     = 1'b0;
                    addr_d    = addr_q + 11'd1;
                    if (cnt_q == ROW_LAST) begin
                        state_d = WLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            WLOAD: begin
                inst_d[0] = 1'b1;
                inst_d[3] = 1'b1;
                if (cnt_q == ROW_LAST) begin
                    state_d = WFLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WFLUSH: begin
                if (cnt_q == COL_LAST) begin
                    state_d = XFILL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            XFILL: begin
                if (!l0_full) begin
                    inst_d[2] = 1'b1;
                    cen_d     = 1'b0;
                    addr_d    = addr_q + 11'd1;
                    if (cnt_q == NIJ_LAST) begin
                        state_d = XEXEC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            XEXEC: begin
                inst_d[1] = 1'b1;
                inst_d[3] = 1'b1;
                if (cnt_q == NIJ_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Only cycles with a row available in the OFIFO count as reads.
            DRAIN: begin
                if (ofifo_valid) begin
                    inst_d[6]  = 1'b1;
                    inst_d[33] = 1'b1;
                    if (cnt_q == ONIJ_LAST) begin
                        cnt_d = '0;
                        if (kij_q == KIJ_LAST) begin
                            state_d = DONE;
                        end else begin
                            state_d = WFILL;
                            kij_d   = kij_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs. Reset aborts any run in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kij_q   <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            cen_q   <= 1'b1;
            xaddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kij_q   <= kij_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            cen_q   <= cen_d;
            xaddr_q <= xaddr_d;
        end
    end

    assign inst      = inst_q;
    assign xmem_cen  = cen_q;
    assign xmem_addr = xaddr_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_corelet_seq.sv
// tb_corelet_seq: self-checking bench for corelet_seq.
//
// A short table of single-cycle vectors covers reset and the first fill
// cycles. Whole runs are then checked against a trace model: for a given
// per-cycle stimulus it lists, cycle by cycle, what kind of work the
// sequencer should be doing and the SRAM address it should present.
// Cycle 0 is the cycle in which start is applied; outputs are sampled 1ns
// after each rising edge.
module tb_corelet_seq;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int NIJ  = 36;
    localparam int ONIJ = 16;
    localparam int KIJ  = 9;
    localparam int MAXC = 4096;

    localparam int A_IDLE  = 0;
    localparam int A_WR    = 1;
    localparam int A_STALL = 2;
    localparam int A_LOAD  = 3;
    localparam int A_FLUSH = 4;
    localparam int A_EXEC  = 5;
    localparam int A_RD    = 6;
    localparam int A_WAIT  = 7;
    localparam int A_DONE  = 8;

    typedef struct {
        logic        rst;
        logic        st;
        logic        full;
        logic        valid;
        logic        expBusy;
        logic        expDone;
        logic [34:0] expInst;
        logic        expCen;
        logic [10:0] expAddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        l0_full;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        xmem_cen;
    logic [10:0] xmem_addr;
    logic        busy;
    logic        done;

    int testsRun    = 0;
    int testsFailed = 0;

    int          actA    [MAXC];
    logic [10:0] addrA   [MAXC];
    bit          fullA   [MAXC];
    bit          validA  [MAXC];
    bit          startA  [MAXC];
    logic [34:0] obsInst [MAXC];
    logic [10:0] obsAddr [MAXC];
    logic        obsCen  [MAXC];
    int          runLen;
    logic [10:0] lastAddr;
    int          doneCycle;
    int          doneCount;
    vec_t        vecs [8];

    always #5 clk = ~clk;

    corelet_seq #(
        .row      (ROW),
        .col      (COL),
        .len_nij  (NIJ),
        .len_onij (ONIJ),
        .len_kij  (KIJ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .l0_full     (l0_full),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .xmem_cen    (xmem_cen),
        .xmem_addr   (xmem_addr),
        .busy        (busy),
        .done        (done)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic f, input logic v);
        reset       = r;
        start       = s;
        l0_full     = f;
        ofifo_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] instFor(input int act);
        logic [34:0] v;
        v = '0;
        case (act)
            A_WR:    v[2] = 1'b1;
            A_LOAD:  begin v[0] = 1'b1; v[3] = 1'b1; end
            A_EXEC:  begin v[1] = 1'b1; v[3] = 1'b1; end
            A_RD:    begin v[6] = 1'b1; v[33] = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic clearStim();
        for (int i = 0; i < MAXC; i++) begin
            fullA[i]  = 1'b0;
            validA[i] = 1'b1;
            startA[i] = 1'b0;
        end
    endtask

    task automatic fillPhase(inout int t, inout logic [10:0] a, input int count);
        int n;
        n = 0;
        while (n < count) begin
            addrA[t] = a;
            if (fullA[t] && t < 3000) begin
                actA[t] = A_STALL;
            end else begin
                actA[t] = A_WR;
                a = a + 11'd1;
                n++;
            end
            t++;
        end
    endtask

    // Expected activity per cycle for a run started in cycle 0.
    task automatic buildModel();
        int          t;
        int          n;
        logic [10:0] a;
        for (int i = 0; i < MAXC; i++) begin
            actA[i]  = A_IDLE;
            addrA[i] = 11'd0;
        end
        addrA[0] = lastAddr;
        t = 1;
        a = 11'd0;
        for (int k = 0; k < KIJ; k++) begin
            fillPhase(t, a, ROW);
            for (int i = 0; i < ROW; i++) begin actA[t] = A_LOAD;  addrA[t] = a; t++; end
            for (int i = 0; i < COL; i++) begin actA[t] = A_FLUSH; addrA[t] = a; t++; end
            fillPhase(t, a, NIJ);
            for (int i = 0; i < NIJ; i++) begin actA[t] = A_EXEC;  addrA[t] = a; t++; end
            n = 0;
            while (n < ONIJ) begin
                addrA[t] = a;
                if (validA[t] || t >= 3000) begin
                    actA[t] = A_RD;
                    n++;
                end else begin
                    actA[t] = A_WAIT;
                end
                t++;
            end
        end
        actA[t] = A_DONE;
        runLen  = t;
        for (int i = t; i < MAXC; i++) addrA[i] = a;
    endtask

    // Drives one run from start to a few idle cycles past completion, or
    // until reset is applied in cycle abortAt (negative means no abort).
    task automatic runOne(input int abortAt);
        int lastT;
        buildModel();
        doneCycle = -1;
        doneCount = 0;
        lastT = (abortAt >= 0) ? abortAt : runLen + 3;
        for (int t = 0; t <= lastT; t++) begin
            applyStimulus(t == abortAt,
                          (t == 0) ? 1'b1 : ((t < runLen) ? startA[t] : 1'b0),
                          fullA[t], validA[t]);
            obsInst[t] = inst;
            obsAddr[t] = xmem_addr;
            obsCen[t]  = xmem_cen;
            if (done === 1'b1) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = t + 1;
            end
            checkOutput($sformatf("excl_wr_rd@%0d", t), inst[2] & inst[3], 1'b0);
            checkOutput($sformatf("excl_load_exec@%0d", t), inst[0] & inst[1], 1'b0);
            if (t == abortAt) begin
                checkOutput("abort_inst", inst, 35'd0);
                checkOutput("abort_cen", xmem_cen, 1'b1);
                checkOutput("abort_addr", xmem_addr, 11'd0);
                checkOutput("abort_busy", busy, 1'b0);
                checkOutput("abort_done", done, 1'b0);
            end else begin
                checkOutput($sformatf("inst@%0d", t), inst, instFor(actA[t]));
                checkOutput($sformatf("cen@%0d", t), xmem_cen, (actA[t] == A_WR) ? 1'b0 : 1'b1);
                checkOutput($sformatf("addr@%0d", t), xmem_addr, addrA[t]);
                checkOutput($sformatf("busy@%0d", t), busy, (actA[t+1] != A_IDLE) ? 1'b1 : 1'b0);
                checkOutput($sformatf("done@%0d", t), done, (actA[t+1] == A_DONE) ? 1'b1 : 1'b0);
            end
        end
        if (abortAt >= 0) begin
            for (int i = 0; i < 20; i++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
                if (done === 1'b1) doneCount++;
                checkOutput("post_abort_busy", busy, 1'b0);
                checkOutput("post_abort_addr", xmem_addr, 11'd0);
            end
            checkOutput("abort_no_done", doneCount, 0);
            lastAddr = 11'd0;
        end else begin
            checkOutput("done_count", doneCount, 1);
            lastAddr = addrA[runLen];
        end
    endtask

    function automatic int countBit(input int bitIdx);
        int c;
        c = 0;
        for (int t = 0; t <= runLen + 3; t++) if (obsInst[t][bitIdx]) c++;
        return c;
    endfunction

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        l0_full     = 1'b0;
        ofifo_valid = 1'b0;
        lastAddr    = 11'd0;

        // rst st full valid | busy done inst cen addr
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 35'h0, 1'b1, 11'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 35'h0, 1'b1, 11'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 35'h0, 1'b1, 11'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 35'h4, 1'b0, 11'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 35'h0, 1'b1, 11'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 35'h4, 1'b0, 11'd1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 35'h0, 1'b1, 11'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 35'h0, 1'b1, 11'd0};

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].full, vecs[i].valid);
            checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("vec%0d_done", i), done, vecs[i].expDone);
            checkOutput($sformatf("vec%0d_inst", i), inst, vecs[i].expInst);
            checkOutput($sformatf("vec%0d_cen", i), xmem_cen, vecs[i].expCen);
            checkOutput($sformatf("vec%0d_addr", i), xmem_addr, vecs[i].expAddr);
        end

        // Nominal run: OFIFO always ready, no backpressure.
        clearStim();
        runOne(-1);
        checkOutput("nominal_done_cycle", doneCycle, 9 * (8 + 8 + 8 + 36 + 36 + 16) + 1);
        checkOutput("nominal_final_addr", xmem_addr, 11'd396);
        checkOutput("nominal_writes", countBit(2), 396);
        checkOutput("nominal_reads", countBit(6), 144);

        // L0 backpressure for three cycles in the middle of the first XFILL.
        clearStim();
        fullA[40] = 1'b1;
        fullA[41] = 1'b1;
        fullA[42] = 1'b1;
        runOne(-1);
        for (int t = 40; t <= 42; t++) begin
            checkOutput($sformatf("bp_l0wr@%0d", t), obsInst[t][2], 1'b0);
            checkOutput($sformatf("bp_cen@%0d", t), obsCen[t], 1'b1);
            checkOutput($sformatf("bp_addr@%0d", t), obsAddr[t], 11'd23);
        end
        checkOutput("bp_writes", countBit(2), 396);
        checkOutput("bp_done_cycle", doneCycle, 9 * 112 + 1 + 3);

        // OFIFO valid alternating: reads follow it one cycle later.
        clearStim();
        for (int t = 0; t < 3000; t++) validA[t] = (t % 2 == 1);
        runOne(-1);
        for (int t = 97; t < 105; t++) begin
            checkOutput($sformatf("drain_rd@%0d", t), obsInst[t][6], validA[t]);
            checkOutput($sformatf("drain_acc@%0d", t), obsInst[t][33], validA[t]);
        end
        checkOutput("drain_reads", countBit(6), 144);
        checkOutput("drain_accs", countBit(33), 144);

        // Start pulsed during WLOAD of the first kernel position.
        clearStim();
        startA[12] = 1'b1;
        runOne(-1);
        checkOutput("ignstart_done_cycle", doneCycle, 9 * 112 + 1);

        // Reset during XEXEC of kij=4, then a fresh run from kij=0.
        clearStim();
        runOne(1 + 4 * 112 + 60 + 11);
        clearStim();
        runOne(-1);
        checkOutput("restart_first_addr", obsAddr[1], 11'd0);
        checkOutput("restart_done_cycle", doneCycle, 9 * 112 + 1);
        checkOutput("restart_final_addr", xmem_addr, 11'd396);

        // Randomized runs: random backpressure, OFIFO readiness and stray starts.
        for (int r = 0; r < 3; r++) begin
            clearStim();
            for (int t = 1; t < 3000; t++) begin
                fullA[t]  = ($urandom_range(0, 3) == 0);
                validA[t] = ($urandom_range(0, 1) == 1);
                startA[t] = ($urandom_range(0, 7) == 0);
            end
            runOne(-1);
            checkOutput($sformatf("rand%0d_writes", r), countBit(2), 396);
            checkOutput($sformatf("rand%0d_reads", r), countBit(6), 144);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/corelet_seq.md
CORELET_SEQ -- requirements
Module: corelet_seq

Interface
REQ-001 SHALL have parameter row, default 8, meaning PE rows and the L0 depth step.
REQ-002 SHALL have parameter col, default 8, meaning PE columns and the post-load flush length.
REQ-003 SHALL have parameter len_nij, default 36, meaning input vectors per kernel position.
REQ-004 SHALL have parameter len_onij, default 16, meaning output vectors drained per kernel position.
REQ-005 SHALL have parameter len_kij, default 9, meaning kernel positions per run.
REQ-006 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle run request, sampled only in IDLE.
REQ-009 SHALL have port l0_full  input  1  L0 cannot accept a write this cycle.
REQ-010 SHALL have port ofifo_valid  input  1  OFIFO holds at least one complete row.
REQ-011 SHALL have port inst  output  35  corelet instruction word: [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [6] ofifo_rd, [33] acc, all other bits 0.
REQ-012 SHALL have port xmem_cen  output  1  active-low activation/weight SRAM enable.
REQ-013 SHALL have port xmem_addr  output  11  activation/weight SRAM read address.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at run completion.

Function
REQ-016 SHALL implement the states IDLE, WFILL, WLOAD, WFLUSH, XFILL, XEXEC, DRAIN, and DONE, all registered; inst, xmem_cen, and xmem_addr SHALL be registered outputs with 1-cycle latency from state/counter.
REQ-017 SHALL move IDLE->WFILL on start; start in any other state SHALL be ignored.
REQ-018 SHALL, in WFILL, assert l0_wr and xmem_cen=0 and increment xmem_addr each write cycle for row writes, then go to WLOAD.
REQ-019 SHALL, in WLOAD, assert inst[0] and l0_rd for row cycles, then go to WFLUSH.
REQ-020 SHALL, in WFLUSH, drive inst=0 for col cycles (weight propagation), then go to XFILL.
REQ-021 SHALL, in XFILL, assert l0_wr and xmem_cen=0 with xmem_addr incrementing for len_nij writes, then go to XEXEC.
REQ-022 SHALL, in XEXEC, assert inst[1] and l0_rd for len_nij cycles, then go to DRAIN.
REQ-023 SHALL, in DRAIN, assert inst[6] and inst[33] only in cycles where ofifo_valid=1, count those reads, and leave after len_onij reads.
REQ-024 SHALL, on leaving DRAIN, go to WFILL with kij+1 if kij<len_kij-1, else go to DONE.
REQ-025 SHALL, in DONE, pulse done for exactly 1 cycle, then return to IDLE.
REQ-026 SHALL, in WFILL/XFILL with l0_full=1, deassert l0_wr and hold xmem_cen=1, xmem_addr, and the write counter (stall); the stall cycle SHALL not count.
REQ-027 SHALL keep xmem_addr contiguous across kij iterations (no wrap within a run) and wrap modulo 2^11.
REQ-028 SHALL never assert l0_wr and l0_rd in the same cycle, nor inst[0] and inst[1] together.
REQ-029 SHALL size each counter as clog2 of its limit plus one; the terminal count SHALL be limit-1 and the counter SHALL clear on state exit.

Reset
REQ-030 SHALL, on reset=1 at a clock edge in any state, force state=IDLE, inst=0, xmem_cen=1, xmem_addr=0, all counters=0, busy=0, done=0; reset SHALL take priority over start.
REQ-031 SHALL abort a run when reset arrives mid-operation, without completing or pulsing done.

Verification
REQ-032 Bench SHALL cover nominal run: start with row=col=8, len_nij=36, len_onij=16, len_kij=9, ofifo_valid tied 1 -> done after 9*(8+8+8+36+36+16)+1 cycles post-start, final xmem_addr=9*44=396.
REQ-033 Bench SHALL cover L0 backpressure: l0_full=1 for 3 cycles mid-XFILL -> l0_wr=0 and address held for those 3 cycles, total writes still 36, done delayed by 3.
REQ-034 Bench SHALL cover DRAIN gating: ofifo_valid toggling 1,0,1,0 -> inst[6] mirrors it with 1-cycle latency, 16 reads counted, inst[33] coincident with each read.
REQ-035 Bench SHALL cover reset mid-run: reset asserted in XEXEC of kij=4 -> next cycle inst=0, busy=0, xmem_addr=0, no done pulse; a later start restarts at kij=0.
REQ-036 Bench SHALL cover ignored start: start pulsed during WLOAD -> no state change and only one done per run.
REQ-037 Bench SHALL check the REQ-028 mutual-exclusion rules every cycle of the REQ-032 run.
